// File: rtl/div_unit.sv
// Sequential restoring divider: 2*WIDTH-bit dividend (hi/lo halves) by a WIDTH-bit divisor.
// One quotient bit per cycle; divide-by-zero and quotient overflow resolve in one cycle.
module div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  typedef enum logic {
    ERR_DZ,
    ERR_OVF
  } err_t;

  state_t           state;
  err_t             err;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step. R is one bit wider than D so the shifted partial
  // remainder is never truncated before the compare.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    r_shift = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    r_next  = r_shift;
    q_next  = q_q << 1;
    if (r_shift >= {1'b0, d_q}) begin
      r_next    = r_shift - {1'b0, d_q};
      q_next[0] = 1'b1;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err      <= ERR_DZ;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      lo_q     <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_q  <= divisor;
            lo_q <= in_lo;
            busy <= 1'b1;
            if (divisor == '0) begin
              err   <= ERR_DZ;
              state <= FIN;
            end else if (in_hi >= divisor) begin
              err   <= ERR_OVF;
              state <= FIN;
            end else begin
              r_q   <= {1'b0, in_hi};
              q_q   <= in_lo;
              count <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end

        CALC: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count - 1'b1;
          // Results are written on the last iteration edge; no separate finish cycle.
          if (count == CW'(1)) begin
            quot     <= q_next;
            rem      <= r_next[WIDTH-1:0];
            div_zero <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        FIN: begin
          quot <= '1;
          if (err == ERR_DZ) begin
            rem      <= lo_q;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else begin
            rem      <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of hand-computed divisions plus reset,
// held-start and back-to-back sequences.
module tb_div_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_hi;
  logic [7:0] in_lo;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_hi    (in_hi),
    .in_lo    (in_lo),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present operands with start=1 for one capture edge; returns #1 after that edge.
  task automatic start_op(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv);
    in_hi   = hi;
    in_lo   = lo;
    divisor = dv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_capture", busy, 1);
  endtask

  // Counts edges after capture until done; lat=0 means the bound expired.
  task automatic wait_done(output int lat, output int busy_drops);
    lat        = 0;
    busy_drops = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_drops++;
    end
    check("done_within_bound", (lat != 0), 1);
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int drops);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_quot"}, quot, v.q);
    check({tag, "_rem"}, rem, v.r);
    check({tag, "_div_zero"}, div_zero, v.dz);
    check({tag, "_overflow"}, overflow, v.ovf);
    check({tag, "_busy_clear"}, busy, 0);
    check({tag, "_busy_held"}, drops, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_quot_held"}, quot, v.q);
    check({tag, "_rem_held"}, rem, v.r);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    int drops;
    start_op(v.hi, v.lo, v.dv);
    wait_done(lat, drops);
    check_result(tag, v, lat, drops);
  endtask

  initial begin
    int   lat;
    int   drops;
    int   dones;
    vec_t v;

    //            hi     lo     dv     q      r      dz    ovf  lat
    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8};
    vecs[1] = '{8'hFE, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[2] = '{8'h00, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1'b0, 1};
    vecs[3] = '{8'h12, 8'h34, 8'h12, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8};
    vecs[5] = '{8'hAB, 8'hCD, 8'hF0, 8'hB7, 8'h3D, 1'b0, 1'b0, 8};
    vecs[6] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[7] = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[8] = '{8'h12, 8'h34, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
    vecs[9] = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8};

    rst     = 1'b1;
    start   = 1'b0;
    in_hi   = '0;
    in_lo   = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quot, 0);
    check("reset_rem", rem, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-operation: flags from the last error vector are set beforehand.
    run_vec("pre_reset", vecs[2]);
    start_op(8'h00, 8'h64, 8'h07);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quot", quot, 0);
    check("midrst_rem", rem, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_overflow", overflow, 0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", busy, 0);
    v = '{8'h00, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8};
    run_vec("after_reset", v);

    // Start held high and operands scrambled while busy: one result, from the captured operands.
    in_hi   = 8'h12;
    in_lo   = 8'h34;
    divisor = 8'h56;
    start   = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      in_hi   = 8'hFF - 8'(n);
      in_lo   = 8'(n * 37);
      divisor = 8'(n);
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("held_done_within_bound", (lat != 0), 1);
    check("held_latency", lat, 8);
    check("held_quot", quot, 8'h36);
    check("held_rem", rem, 8'h10);
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("held_single_done", dones, 0);
    check("held_idle", busy, 0);

    // Back-to-back: new start in the done cycle is accepted.
    start_op(8'h00, 8'h64, 8'h07);
    wait_done(lat, drops);
    check("b2b_first_quot", quot, 8'h0E);
    check("b2b_first_rem", rem, 8'h02);
    check("b2b_done_busy_low", busy, 0);
    start_op(8'h00, 8'hFF, 8'h10);
    check("b2b_done_cleared", done, 0);
    wait_done(lat, drops);
    v = '{8'h00, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 8};
    check_result("b2b_second", v, lat, drops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential restoring divider in the arithmetic-extension group.
- Sits directly downstream of the 8x8 multiplier. It takes a 2*WIDTH-bit dividend as separate hi/lo halves, matching the multiplier's product outputs, plus a WIDTH-bit divisor.
- Produces a WIDTH-bit quotient and remainder after WIDTH iteration cycles.
- Flags divide-by-zero and quotient overflow.

Parameters:
- WIDTH, 8, operand width. Dividend is 2*WIDTH bits; divisor, quotient and remainder are WIDTH bits each.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- in_hi  in  WIDTH  dividend upper half.
- in_lo  in  WIDTH  dividend lower half.
- divisor  in  WIDTH  divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quot  out  WIDTH  quotient; held until next completion.
- rem  out  WIDTH  remainder; held until next completion.
- div_zero  out  1  divisor was 0 (valid with done, held).
- overflow  out  1  in_hi >= divisor, quotient does not fit (valid with done, held).

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - All outputs go to 0: busy, done, quot, rem, div_zero, overflow. Internal state goes to IDLE.
  - Reset overrides everything, including mid-operation; no done pulse follows and the in-flight result is discarded.
- States: IDLE, CALC, FIN.
- IDLE:
  - done=0 except in the cycle right after completion.
  - Operand capture: on an edge with start=1, capture in_hi, in_lo and divisor into internal registers; later input changes are ignored. The next state depends on the captured divisor:
    - divisor==0: go to FIN with err=dz.
    - else if in_hi >= divisor: go to FIN with err=ovf.
    - else: go to CALC. R (WIDTH+1 bits) := in_hi, Q := in_lo, count := WIDTH.
  - busy=1 from the capture edge onward.
- CALC, one bit per edge:
  - {R,Q} := {R,Q} << 1.
  - If R >= D: R := R - D and Q[0] := 1.
  - count decrements by 1.
  - On the edge where count goes 1->0: write quot := Q and rem := R[WIDTH-1:0], clear div_zero and overflow, set done=1, clear busy, and return to IDLE. No extra FIN cycle is used on the normal path.
- FIN (error path only), one edge after capture:
  - div_zero: quot := all ones, rem := captured in_lo, div_zero=1, overflow=0.
  - overflow: quot := all ones, rem := 0, overflow=1, div_zero=0.
  - Both cases: done=1, busy=0, go to IDLE.
- Latency from the start-capture edge E0:
  - Normal path: result and done appear at edge E+WIDTH, e.g. E8 for WIDTH=8.
  - Error path: result and done appear at edge E+1.
- done is high for exactly one cycle and clears at the next edge unless a new completion occurs.
- Back-to-back: start=1 during the done cycle is accepted, because busy is already 0.
- start while busy=1 is ignored: no queueing, no effect on the running operation.
- Invariant: in_hi < divisor is checked before CALC, so the final quotient always fits WIDTH bits.
- Invariant: the remainder always satisfies rem < divisor.
- R carries WIDTH+1 bits so the shifted value never truncates before comparison.
- Outputs hold their last values while IDLE and during a subsequent CALC, until overwritten at completion.

Test Plan:
- Normal divide: start with in_hi=0x12, in_lo=0x34, divisor=0x56 -> done exactly 8 cycles after capture; quot=0x36, rem=0x10, flags 0; busy high for 8 cycles.
- Chained from multiplier: in_hi=0xFE, in_lo=0x01, divisor=0xFF -> quot=0xFF, rem=0x00, flags 0.
- Divide-by-zero: in_hi=0x00, in_lo=0x2A, divisor=0x00 -> done 1 cycle after capture; div_zero=1, quot=0xFF, rem=0x2A.
- Overflow: in_hi=0x12, in_lo=0x34, divisor=0x12 -> done 1 cycle after capture; overflow=1, quot=0xFF, rem=0x00.
- Reset mid-operation: start 0x0064/0x07, assert rst at cycle 4 -> all outputs 0, no done pulse.
  - Follow-up: next start 0x0064/0x07 yields quot=0x0E, rem=0x02.
- Ignore and back-to-back:
  - start held high during busy -> only one done.
  - start in the done cycle with 0x00FF/0x10 -> accepted; quot=0x0F, rem=0x0F after 8 more cycles.
